// File: rtl/spi_flash_reader_pkg.sv
// -----------------------------------------------------------------------------
// spi_flash_reader_pkg
// Shared definitions for the SPI NOR-flash read master:
//   CMD_READ  - standard single-bit READ opcode sent first in every transaction
//   CMD_BITS  - length of the opcode + 24-bit address header
//   state_e   - top-level FSM state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package spi_flash_reader_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam int         CMD_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/spi_flash_reader_if.sv
// -----------------------------------------------------------------------------
// spi_flash_reader_if
// Bundles the flash pins and the fabric-side request/response signals.
//   spi_mosi/spi_miso/spi_cs_n/spi_clk - SPI mode 0, single-bit flash pins
//   addr/len/go/rdy                    - read request handshake
//   data/valid                         - received byte stream
//
// Handshake: a request is accepted on a clock edge where go=1 and rdy=1;
// addr and len are sampled on that edge only. go while rdy=0 is ignored.
// valid is a one-cycle strobe per byte with no back-pressure; data holds
// the last byte until the next strobe.
//
// modport master - the read engine (drives pins and response)
// modport slave  - the environment (flash model + consumer)
// -----------------------------------------------------------------------------
interface spi_flash_reader_if;

  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;
  logic        spi_clk;
  logic [23:0] addr;
  logic [15:0] len;
  logic        go;
  logic        rdy;
  logic [7:0]  data;
  logic        valid;

  modport master (
    output spi_mosi, spi_cs_n, spi_clk, rdy, data, valid,
    input  spi_miso, addr, len, go
  );

  modport slave (
    input  spi_mosi, spi_cs_n, spi_clk, rdy, data, valid,
    output spi_miso, addr, len, go
  );

endinterface

// File: rtl/spi_flash_reader_phy.sv
// -----------------------------------------------------------------------------
// spi_shift_phy
// clk/2 SPI clock generator with a 32-bit transmit shifter and an 8-bit
// receive shifter. One bit = LOW phase (mosi updated) + HIGH phase; miso is
// captured on the edge that ends the HIGH phase.
//   clk, rst     - system clock, synchronous active-high reset
//   start_i      - load load_i and begin clocking (one setup cycle first)
//   load_i       - 32-bit word shifted out MSB first, zeros afterwards
//   stop_i       - end clocking on this edge (returns sclk/mosi low)
//   miso_i       - serial input
//   sclk_o       - SPI clock (registered)
//   mosi_o       - serial output (registered)
//   byte_done_o  - this edge captures the 8th bit of a byte
//   word_done_o  - this edge captures the 32nd bit since start
//   rx_byte_o    - byte assembled including the bit captured on this edge
// -----------------------------------------------------------------------------
module spi_shift_phy (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] load_i,
  input  logic        stop_i,
  input  logic        miso_i,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        byte_done_o,
  output logic        word_done_o,
  output logic [7:0]  rx_byte_o
);

  logic        busy_q, busy_d;
  logic        setup_q, setup_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [31:0] tx_q, tx_d;
  logic [6:0]  rx_q, rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        capture;

  // The capture edge is the one ending a HIGH phase.
  assign capture     = busy_q && !setup_q && sclk_q;
  assign byte_done_o = capture && (bit_cnt_q[2:0] == 3'd7);
  assign word_done_o = capture && (bit_cnt_q == 5'd31);
  assign rx_byte_o   = {rx_q, miso_i};
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;

  always_comb begin
    busy_d    = busy_q;
    setup_d   = setup_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_cnt_d = bit_cnt_q;
    if (start_i) begin
      busy_d    = 1'b1;
      setup_d   = 1'b1;
      sclk_d    = 1'b0;
      mosi_d    = 1'b0;
      tx_d      = load_i;
      bit_cnt_d = 5'd0;
    end else if (busy_q) begin
      if (setup_q) begin
        // First LOW phase: present the MSB while chip select falls.
        setup_d = 1'b0;
        mosi_d  = tx_q[31];
        tx_d    = {tx_q[30:0], 1'b0};
      end else if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        // End of HIGH phase: sample miso, start next LOW phase.
        sclk_d    = 1'b0;
        rx_d      = {rx_q[5:0], miso_i};
        bit_cnt_d = bit_cnt_q + 5'd1;
        mosi_d    = tx_q[31];
        tx_d      = {tx_q[30:0], 1'b0};
      end
      if (stop_i) begin
        busy_d  = 1'b0;
        setup_d = 1'b0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      setup_q   <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      busy_q    <= busy_d;
      setup_q   <= setup_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// -----------------------------------------------------------------------------
// spi_flash_reader
// Autonomous SPI NOR-flash read master. On an accepted request it sends
// {CMD_READ, addr} and streams len+1 bytes to the fabric as valid strobes.
//   clk, rst     - system clock, synchronous active-high reset
//   bus          - flash pins and request/response handshake (master side)
//   dbg_state_o  - current FSM state
// Timing from the accept edge (edge 0): cs_n low after edge 1, first spi_clk
// rise after edge 2, first valid after edge 81, then every 16 cycles.
// -----------------------------------------------------------------------------
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter logic [7:0] CMD_READ = spi_flash_reader_pkg::CMD_READ
) (
  input  logic                clk,
  input  logic                rst,
  spi_flash_reader_if.master  bus,
  output state_e              dbg_state_o
);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        rdy_q, rdy_d;
  logic        cs_n_q, cs_n_d;

  logic        accept;
  logic        last_byte;
  logic        phy_stop;
  logic        phy_sclk;
  logic        phy_mosi;
  logic        byte_done;
  logic        word_done;
  logic [7:0]  rx_byte;

  assign accept    = bus.go && rdy_q;
  assign last_byte = (cnt_q == len_q);
  assign phy_stop  = (state_q == ST_DATA) && byte_done && last_byte;

  spi_shift_phy u_phy (
    .clk         (clk),
    .rst         (rst),
    .start_i     (accept),
    .load_i      ({CMD_READ, bus.addr}),
    .stop_i      (phy_stop),
    .miso_i      (bus.spi_miso),
    .sclk_o      (phy_sclk),
    .mosi_o      (phy_mosi),
    .byte_done_o (byte_done),
    .word_done_o (word_done),
    .rx_byte_o   (rx_byte)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = bus.len;
          cnt_d   = 16'd0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (word_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (byte_done) begin
          data_d  = rx_byte;
          valid_d = 1'b1;
          if (last_byte) state_d = ST_DONE;
          else           cnt_d   = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d  = (state_d == ST_IDLE);
    // Chip select falls one cycle after acceptance (the phy setup cycle)
    // and rises together with the final valid.
    cs_n_d = !(((state_d == ST_CMD) || (state_d == ST_DATA)) && (state_q != ST_IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_clk  = phy_sclk;
  assign bus.spi_mosi = phy_mosi;
  assign bus.rdy      = rdy_q;
  assign bus.valid    = valid_q;
  assign bus.data     = data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
module tb_spi_flash_reader;
  import spi_flash_reader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_flash_reader_if bus ();
  state_e dbg_state;

  spi_flash_reader #(.CMD_READ(8'h03)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];     // expected received bytes
  logic [47:0] txn_q[$];     // {expected command word, expected spi_clk pulses}

  // Flash model + pin monitor, sampled on the falling clk edge.
  logic        prev_sclk = 1'b0;
  logic        prev_cs   = 1'b1;
  logic [31:0] mon_cmd   = '0;
  int          mon_bits  = 0;
  logic [47:0] mon_e;

  always @(negedge clk) begin
    if (rst) begin
      bus.spi_miso = 1'b0;
      prev_sclk    = 1'b0;
      prev_cs      = 1'b1;
      mon_cmd      = '0;
      mon_bits     = 0;
    end else begin
      if (bus.spi_clk && !prev_sclk) begin
        check("cs_low_on_sclk_rise", bus.spi_cs_n, 0);
        if (mon_bits < 32) mon_cmd = {mon_cmd[30:0], bus.spi_mosi};
        else               check("mosi_zero_in_data", bus.spi_mosi, 0);
        mon_bits++;
      end
      if (!bus.spi_clk && prev_sclk) bus.spi_miso = ~bus.spi_miso;
      if (bus.spi_cs_n && !prev_cs) begin
        check("txn_expected", txn_q.size() != 0, 1);
        if (txn_q.size() != 0) begin
          mon_e = txn_q.pop_front();
          check("cmd_word", mon_cmd, mon_e[47:16]);
          check("sclk_pulses", mon_bits, {16'd0, mon_e[15:0]});
        end
        mon_bits = 0;
        mon_cmd  = '0;
      end
      if (bus.valid) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", bus.data, exp_q.pop_front());
        check("rdy_low_with_valid", bus.rdy, 0);
      end
      prev_sclk = bus.spi_clk;
      prev_cs   = bus.spi_cs_n;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [23:0] addr;
    logic [15:0] len;
    logic [31:0] exp_cmd;
    int          exp_pulses;
    int          exp_first;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver ----------------
  task automatic run_txn(input logic [23:0] a, input logic [15:0] l,
                         input logic [31:0] exp_cmd, input int exp_pulses,
                         input int exp_first);
    bit got;
    int k;
    int nbytes;
    int last_v;
    int limit;
    got = 0;
    for (int w = 0; w < 200; w++) begin
      if (bus.rdy && !bus.valid) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rdy_before_go", got, 1);
    if (!got) return;
    txn_q.push_back({exp_cmd, exp_pulses[15:0]});
    for (int b = 0; b <= int'(l); b++) exp_q.push_back(8'h55);
    bus.addr = a;
    bus.len  = l;
    bus.go   = 1'b1;
    @(posedge clk); #1;               // accept edge
    bus.go   = 1'b0;
    bus.addr = ~a;                    // late changes must be ignored
    bus.len  = 16'hFFFF;
    check("rdy_low_after_accept", bus.rdy, 0);
    check("cs_high_at_accept", bus.spi_cs_n, 1);
    nbytes = 0;
    last_v = 0;
    k      = 0;
    limit  = exp_first + 16 * int'(l) + 20;
    for (int i = 1; i <= limit + 1; i++) begin
      k = i;
      if (i > limit) break;
      bus.go = (i == 9 || i == 69);   // requests while busy
      @(posedge clk); #1;
      if (i == 1) check("cs_low_edge1", bus.spi_cs_n, 0);
      if (i == 1) check("sclk_low_edge1", bus.spi_clk, 0);
      if (i == 2) check("sclk_rise_edge2", bus.spi_clk, 1);
      if (bus.valid) begin
        nbytes++;
        if (nbytes == 1) check("first_valid_latency", i, exp_first);
        else             check("valid_spacing", i - last_v, 16);
        last_v = i;
        if (nbytes == int'(l) + 1) check("cs_high_with_last_valid", bus.spi_cs_n, 1);
      end
      if (bus.rdy) break;
    end
    bus.go = 1'b0;
    check("byte_count", nbytes, int'(l) + 1);
    check("txn_finished", bus.rdy, 1);
    check("rdy_one_after_last", k - last_v, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.go   = 1'b0;
    bus.addr = '0;
    bus.len  = '0;

    vecs[0] = '{24'h00BABE, 16'd0, 32'h0300BABE, 40, 81};
    vecs[1] = '{24'h00BABF, 16'd0, 32'h0300BABF, 40, 81};
    vecs[2] = '{24'h00BAC0, 16'd0, 32'h0300BAC0, 40, 81};
    vecs[3] = '{24'h123456, 16'd3, 32'h03123456, 64, 81};
    vecs[4] = '{24'hFFFFFF, 16'd1, 32'h03FFFFFF, 48, 81};
    vecs[5] = '{24'h000000, 16'd2, 32'h03000000, 56, 81};
    for (int i = 6; i < 8; i++) begin
      vecs[i].addr       = 24'($urandom_range(0, 32'h00FFFFFF));
      vecs[i].len        = 16'($urandom_range(0, 2));
      vecs[i].exp_cmd    = {8'h03, vecs[i].addr};
      vecs[i].exp_pulses = 32 + 8 * (int'(vecs[i].len) + 1);
      vecs[i].exp_first  = 81;
    end

    // Reset held for 200 ns.
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_cs_n", bus.spi_cs_n, 1);
    check("rst_sclk", bus.spi_clk, 0);
    check("rst_mosi", bus.spi_mosi, 0);
    check("rst_rdy", bus.rdy, 1);
    check("rst_valid", bus.valid, 0);
    check("rst_data", bus.data, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // Reset in the middle of the command phase aborts at once.
    @(posedge clk); #1;
    bus.addr = 24'h111111;
    bus.len  = 16'd0;
    bus.go   = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("cs_low_mid_cmd", bus.spi_cs_n, 0);
    check("state_cmd_mid", dbg_state, ST_CMD);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_cs_n", bus.spi_cs_n, 1);
    check("abort_rdy", bus.rdy, 1);
    check("abort_sclk", bus.spi_clk, 0);
    check("abort_valid", bus.valid, 0);
    check("abort_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: back-to-back single reads, bursts, random reads.
    for (int i = 0; i < 8; i++)
      run_txn(vecs[i].addr, vecs[i].len, vecs[i].exp_cmd, vecs[i].exp_pulses, vecs[i].exp_first);

    repeat (4) @(posedge clk);
    #1;
    check("idle_after_all", bus.spi_cs_n, 1);
    check("bytes_drained", exp_q.size(), 0);
    check("txns_drained", txn_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
